// File: rtl/enc8b10b_tx_ctrl.sv
// Slot sequencer in front of the 8b/10b encoder: alignment, idle fill, packet data and skip insertion.
// Optional feature macro LINK_RETRAIN_EN adds a retrain input that forces the link back into ALIGN.
//
// state | meaning
// ALIGN | sending K28.5 alignment words, link down
// IDLE  | link up, between packets; idle fill or start of a packet
// DATA  | inside a packet (in_pkt)
// SKIP  | emitting K28.0 clock-compensation words
module enc8b10b_tx_ctrl #(
    parameter int ALIGN_CNT     = 16,
    parameter int SKIP_INTERVAL = 1024,
    parameter int SKIP_LEN      = 2
) (
    input  logic       clk,
    input  logic       rst,
`ifdef LINK_RETRAIN_EN
    input  logic       retrain,
`endif
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_k,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       enc_ready,
    output logic       enc_valid,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       link_up,
    output logic       tx_underrun
);

    localparam int AW = $clog2(ALIGN_CNT + 1);
    localparam int WW = $clog2(SKIP_INTERVAL);
    localparam int SW = $clog2(SKIP_LEN + 1);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        IDLE  = 2'd1,
        DATA  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   align_cnt_q, align_cnt_d;
    logic [WW-1:0]   word_cnt_q, word_cnt_d;
    logic [SW-1:0]   skip_cnt_q, skip_cnt_d;
    logic            skip_pending_q, skip_pending_d;
    logic            link_up_q, link_up_d;
    logic            enc_valid_q, enc_valid_d;
    logic [7:0]      enc_data_q, enc_data_d;
    logic            enc_k_q, enc_k_d;
    logic            tx_underrun_q, tx_underrun_d;

    logic            load;
    logic            in_pkt;
    logic            ready_int;
    logic            accept;
    logic            retrain_req;
    logic            emit_skip;

`ifdef LINK_RETRAIN_EN
    assign retrain_req = retrain;
`else
    assign retrain_req = 1'b0;
`endif

    assign load      = enc_ready | ~enc_valid_q;
    assign in_pkt    = (state_q == DATA);
    // A pending skip blocks new packets but never splits one already in flight.
    assign ready_int = rst & load & link_up_q & (state_q != SKIP)
                     & ~(skip_pending_q & ~in_pkt) & ~retrain_req;
    assign accept    = s_valid & ready_int;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ALIGN;
            align_cnt_q    <= '0;
            word_cnt_q     <= '0;
            skip_cnt_q     <= '0;
            skip_pending_q <= 1'b0;
            link_up_q      <= 1'b0;
            enc_valid_q    <= 1'b0;
            enc_data_q     <= K28_5;
            enc_k_q        <= 1'b1;
            tx_underrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            align_cnt_q    <= align_cnt_d;
            word_cnt_q     <= word_cnt_d;
            skip_cnt_q     <= skip_cnt_d;
            skip_pending_q <= skip_pending_d;
            link_up_q      <= link_up_d;
            enc_valid_q    <= enc_valid_d;
            enc_data_q     <= enc_data_d;
            enc_k_q        <= enc_k_d;
            tx_underrun_q  <= tx_underrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        align_cnt_d    = align_cnt_q;
        word_cnt_d     = word_cnt_q;
        skip_cnt_d     = skip_cnt_q;
        skip_pending_d = skip_pending_q;
        link_up_d      = link_up_q;
        enc_valid_d    = enc_valid_q;
        enc_data_d     = enc_data_q;
        enc_k_d        = enc_k_q;
        tx_underrun_d  = 1'b0;
        emit_skip      = 1'b0;

        if (load) begin
            enc_valid_d = 1'b1;
            enc_data_d  = K28_5;
            enc_k_d     = 1'b1;

            case (state_q)
                ALIGN: begin
                    align_cnt_d = align_cnt_q + AW'(1);
                    if (align_cnt_q == AW'(ALIGN_CNT - 1)) begin
                        link_up_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                IDLE, DATA: begin
                    if (state_q == IDLE && skip_pending_q) begin
                        emit_skip = 1'b1;
                    end else begin
                        if (word_cnt_q != WW'(SKIP_INTERVAL - 1)) begin
                            word_cnt_d = word_cnt_q + WW'(1);
                            if (word_cnt_q == WW'(SKIP_INTERVAL - 2))
                                skip_pending_d = 1'b1;
                        end
                        if (accept) begin
                            enc_data_d = s_data;
                            enc_k_d    = s_k;
                            state_d    = s_last ? IDLE : DATA;
                        end else if (state_q == DATA) begin
                            tx_underrun_d = 1'b1;
                        end
                    end
                end
                SKIP: begin
                    emit_skip = 1'b1;
                end
            endcase

            // skip_cnt counts K28.0 words already sent in this burst, including the entry slot.
            if (emit_skip) begin
                enc_data_d = K28_0;
                if (skip_cnt_q == SW'(SKIP_LEN - 1)) begin
                    state_d        = IDLE;
                    skip_cnt_d     = '0;
                    skip_pending_d = 1'b0;
                    word_cnt_d     = '0;
                end else begin
                    state_d    = SKIP;
                    skip_cnt_d = skip_cnt_q + SW'(1);
                end
            end

            if (retrain_req) begin
                state_d        = ALIGN;
                align_cnt_d    = '0;
                word_cnt_d     = '0;
                skip_cnt_d     = '0;
                skip_pending_d = 1'b0;
                link_up_d      = 1'b0;
                enc_data_d     = K28_5;
                enc_k_d        = 1'b1;
                tx_underrun_d  = 1'b0;
            end
        end
    end

    assign s_ready     = ready_int;
    assign enc_valid   = enc_valid_q;
    assign enc_data    = enc_data_q;
    assign enc_k       = enc_k_q;
    assign link_up     = link_up_q;
    assign tx_underrun = tx_underrun_q;

endmodule
